// File: rtl/seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// seven_segment_scanner
//
// Time-multiplexes four 7-segment codes onto one shared segment bus and four
// active-low digit enables. Each digit owns a slot of SCAN_DIV clock cycles;
// the last BLANK_CYCLES cycles of every slot drive all digits off so the
// previous digit's segments cannot ghost onto the next one. The four codes are
// captured into a shadow register once per frame, so a change on dec_in never
// tears a frame that is already being displayed.
//
// Parameters:
//   SCAN_DIV      clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  blanked cycles at the end of each slot (1 .. SCAN_DIV-1)
//
// Ports:
//   clk          system clock, rising-edge active
//   reset_n      asynchronous active-low reset; blanks the display at once
//   en           1 = scan, 0 = pause (state held, display blanked)
//   dec_in       packed codes {digit3, digit2, digit1, digit0}, 7 bits each,
//                segment bits active-high
//   seg_out      segment drive for the selected digit, active-high
//   an_n         digit enables, active-low, an_n[i] selects digit i
//   frame_start  high during the first cycle of digit 0 in each frame
// -----------------------------------------------------------------------------
module seven_segment_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [27:0] dec_in,
    output logic [6:0]  seg_out,
    output logic [3:0]  an_n,
    output logic        frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Last slot cycle, and first cycle of the blank window inside a slot.
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_BEG = CNT_W'(SCAN_DIV - BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       dig;
    logic [27:0]      shd;
    logic [6:0]       field;

    // Reset parks the scanner on the last cycle of digit 3. That cycle lies
    // inside the blank window, so asserting reset_n blanks the outputs without
    // a clock edge, and the first enabled edge afterwards is a frame boundary
    // that loads shd and starts digit 0.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= CNT_MAX;
            dig <= 2'd3;
            shd <= 28'h0;
        end else if (en) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                dig <= dig + 2'd1;
                if (dig == 2'd3) begin
                    shd <= dec_in;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are decoded from the held state and en only; dec_in reaches the
    // display solely through shd.
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        field       = 7'h00;
        seg_out     = 7'h00;
        an_n        = 4'b1111;
        frame_start = 1'b0;

        case (dig)
            2'd0:    field = shd[6:0];
            2'd1:    field = shd[13:7];
            2'd2:    field = shd[20:14];
            default: field = shd[27:21];
        endcase

        if (en) begin
            frame_start = (dig == 2'd0) && (cnt == '0);
            if (cnt < BLANK_BEG) begin
                an_n    = ~(4'b0001 << dig);
                seg_out = field;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Directed bench for seven_segment_scanner. One instance uses the default
// parameters, a second uses SCAN_DIV=8 / BLANK_CYCLES=3; both share clock,
// reset and inputs. Outputs are sampled 1 time unit after the rising edge and
// inputs are changed at that point too, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_seven_segment_scanner;

    localparam logic [27:0] OLD_CODES = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [27:0] NEW_CODES = 28'h0FFFFFF;
    localparam logic [27:0] RST_CODES = {7'h3F, 7'h06, 7'h5B, 7'h4F};

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        en = 1'b0;
    logic [27:0] dec_in = 28'h0;

    logic [6:0]  seg_out;
    logic [3:0]  an_n;
    logic        frame_start;

    logic [6:0]  seg8;
    logic [3:0]  an8_n;
    logic        fs8;

    int errors = 0;
    int checks = 0;

    // Digit-enable pattern over one default frame (3 lit + 1 blank per digit).
    logic [3:0] an_pat [16] = '{4'hE, 4'hE, 4'hE, 4'hF,
                                4'hD, 4'hD, 4'hD, 4'hF,
                                4'hB, 4'hB, 4'hB, 4'hF,
                                4'h7, 4'h7, 4'h7, 4'hF};

    seven_segment_scanner u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .dec_in      (dec_in),
        .seg_out     (seg_out),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    seven_segment_scanner #(.SCAN_DIV(8), .BLANK_CYCLES(3)) u_dut8 (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .dec_in      (dec_in),
        .seg_out     (seg8),
        .an_n        (an8_n),
        .frame_start (fs8)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across two edges, then release just after an edge so the next
    // edge is "edge 1" of the run.
    task automatic do_reset(input logic [27:0] codes);
        reset_n = 1'b0;
        en      = 1'b1;
        dec_in  = codes;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        en     = 1'b1;
        dec_in = OLD_CODES;
        #1;
        reset_n = 1'b0;
        #1;
        // No rising edge has occurred yet: clk first rises at t=5.
        checks++;
        if ({an_n, seg_out, frame_start} !== {4'b1111, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_default: got an_n=%b seg=%h fs=%b, want an_n=1111 seg=00 fs=0",
                     an_n, seg_out, frame_start);
        end
        checks++;
        if ({an8_n, seg8, fs8} !== {4'b1111, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_div8: got an_n=%b seg=%h fs=%b, want an_n=1111 seg=00 fs=0",
                     an8_n, seg8, fs8);
        end
    endtask

    task automatic test_nominal();
        logic [6:0] seg_tab [16] = '{7'h66, 7'h66, 7'h66, 7'h00,
                                     7'h4F, 7'h4F, 7'h4F, 7'h00,
                                     7'h5B, 7'h5B, 7'h5B, 7'h00,
                                     7'h06, 7'h06, 7'h06, 7'h00};
        logic exp_fs;
        do_reset(OLD_CODES);
        for (int e = 1; e <= 17; e++) begin
            step();
            exp_fs = ((e - 1) % 16 == 0);
            checks++;
            if ({an_n, seg_out, frame_start} !==
                {an_pat[(e-1)%16], seg_tab[(e-1)%16], exp_fs}) begin
                errors++;
                $display("FAIL nominal edge %0d: got an_n=%b seg=%h fs=%b, want an_n=%b seg=%h fs=%b",
                         e, an_n, seg_out, frame_start,
                         an_pat[(e-1)%16], seg_tab[(e-1)%16], exp_fs);
            end
        end
    endtask

    task automatic test_mid_frame_update();
        logic [6:0] seg_tab [32] = '{7'h66, 7'h66, 7'h66, 7'h00,
                                     7'h4F, 7'h4F, 7'h4F, 7'h00,
                                     7'h5B, 7'h5B, 7'h5B, 7'h00,
                                     7'h06, 7'h06, 7'h06, 7'h00,
                                     7'h7F, 7'h7F, 7'h7F, 7'h00,
                                     7'h7F, 7'h7F, 7'h7F, 7'h00,
                                     7'h7F, 7'h7F, 7'h7F, 7'h00,
                                     7'h07, 7'h07, 7'h07, 7'h00};
        logic exp_fs;
        do_reset(OLD_CODES);
        for (int e = 1; e <= 32; e++) begin
            step();
            exp_fs = (e == 1) || (e == 17);
            checks++;
            if ({an_n, seg_out, frame_start} !==
                {an_pat[(e-1)%16], seg_tab[e-1], exp_fs}) begin
                errors++;
                $display("FAIL mid_update edge %0d: got an_n=%b seg=%h fs=%b, want an_n=%b seg=%h fs=%b",
                         e, an_n, seg_out, frame_start,
                         an_pat[(e-1)%16], seg_tab[e-1], exp_fs);
            end
            // Change codes while digit 1 is on screen.
            if (e == 5) dec_in = NEW_CODES;
        end
    endtask

    task automatic test_pause();
        do_reset(OLD_CODES);
        repeat (10) step();   // now at digit 2, cnt 1
        checks++;
        if ({an_n, seg_out} !== {4'b1011, 7'h5B}) begin
            errors++;
            $display("FAIL pause_pre: got an_n=%b seg=%h, want an_n=1011 seg=5b", an_n, seg_out);
        end
        en = 1'b0;
        #1;
        checks++;
        if ({an_n, seg_out, frame_start} !== {4'b1111, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL pause_drop: got an_n=%b seg=%h fs=%b, want an_n=1111 seg=00 fs=0",
                     an_n, seg_out, frame_start);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if ({an_n, seg_out, frame_start} !== {4'b1111, 7'h00, 1'b0}) begin
                errors++;
                $display("FAIL pause_hold %0d: got an_n=%b seg=%h fs=%b, want an_n=1111 seg=00 fs=0",
                         i, an_n, seg_out, frame_start);
            end
        end
        en = 1'b1;
        #1;
        checks++;
        if ({an_n, seg_out, frame_start} !== {4'b1011, 7'h5B, 1'b0}) begin
            errors++;
            $display("FAIL pause_resume: got an_n=%b seg=%h fs=%b, want an_n=1011 seg=5b fs=0",
                     an_n, seg_out, frame_start);
        end
        step();
        checks++;
        if ({an_n, seg_out, frame_start} !== {4'b1011, 7'h5B, 1'b0}) begin
            errors++;
            $display("FAIL pause_lit2: got an_n=%b seg=%h fs=%b, want an_n=1011 seg=5b fs=0",
                     an_n, seg_out, frame_start);
        end
        step();
        checks++;
        if ({an_n, seg_out, frame_start} !== {4'b1111, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL pause_blank: got an_n=%b seg=%h fs=%b, want an_n=1111 seg=00 fs=0",
                     an_n, seg_out, frame_start);
        end
        step();
        checks++;
        if ({an_n, seg_out, frame_start} !== {4'b0111, 7'h06, 1'b0}) begin
            errors++;
            $display("FAIL pause_next_digit: got an_n=%b seg=%h fs=%b, want an_n=0111 seg=06 fs=0",
                     an_n, seg_out, frame_start);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] an_tab  [4] = '{4'hE, 4'hE, 4'hE, 4'hF};
        logic [6:0] seg_tab [4] = '{7'h4F, 7'h4F, 7'h4F, 7'h00};
        do_reset(OLD_CODES);
        repeat (6) step();    // digit 1, cnt 1
        checks++;
        if ({an_n, seg_out} !== {4'b1101, 7'h4F}) begin
            errors++;
            $display("FAIL rst_mid_pre: got an_n=%b seg=%h, want an_n=1101 seg=4f", an_n, seg_out);
        end
        #3;
        reset_n = 1'b0;
        dec_in  = RST_CODES;
        #1;
        checks++;
        if ({an_n, seg_out, frame_start} !== {4'b1111, 7'h00, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_async: got an_n=%b seg=%h fs=%b, want an_n=1111 seg=00 fs=0",
                     an_n, seg_out, frame_start);
        end
        #1;
        reset_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++;
            if ({an_n, seg_out, frame_start} !== {an_tab[e-1], seg_tab[e-1], e == 1}) begin
                errors++;
                $display("FAIL rst_mid_restart edge %0d: got an_n=%b seg=%h fs=%b, want an_n=%b seg=%h fs=%b",
                         e, an_n, seg_out, frame_start, an_tab[e-1], seg_tab[e-1], e == 1);
            end
        end
    endtask

    task automatic test_params();
        logic [3:0] an_lit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] codes  [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fs;
        int         slot;
        int         d;
        do_reset(OLD_CODES);
        for (int e = 1; e <= 33; e++) begin
            step();
            slot    = (e - 1) % 8;
            d       = ((e - 1) / 8) % 4;
            exp_an  = (slot < 5) ? an_lit[d] : 4'hF;
            exp_seg = (slot < 5) ? codes[d] : 7'h00;
            exp_fs  = (slot == 0) && (d == 0);
            checks++;
            if ({an8_n, seg8, fs8} !== {exp_an, exp_seg, exp_fs}) begin
                errors++;
                $display("FAIL div8 edge %0d: got an_n=%b seg=%h fs=%b, want an_n=%b seg=%h fs=%b",
                         e, an8_n, seg8, fs8, exp_an, exp_seg, exp_fs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mid_frame_update();
        test_pause();
        test_reset_mid();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
